// File: rtl/assoc_cache_pkg.sv
// Shared types and geometry helpers for the two-way set-associative cache.
//   state_t     : controller states
//   tag_entry_t : per-way {valid, dirty, tag}. The tag field has a fixed
//                 maximum width; ways zero-extend their stored tag into it.
//   off_w/idx_w/tag_w : derived address-field widths for a given geometry
package assoc_cache_pkg;

    localparam int TAG_MAX_W = 32;

    typedef enum logic [2:0] {
        IDLE,
        COMPARE,
        WRITE_BACK,
        ALLOCATE,
        FLUSH_SCAN,
        FLUSH_WB
    } state_t;

    typedef struct packed {
        logic                 valid;
        logic                 dirty;
        logic [TAG_MAX_W-1:0] tag;
    } tag_entry_t;

    function automatic int off_w(input int words);
        return $clog2(words);
    endfunction

    function automatic int idx_w(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int tag_w(input int addr_w, input int words, input int sets);
        return addr_w - $clog2(words) - $clog2(sets);
    endfunction

endpackage

// File: rtl/assoc_cache_way.sv
// One way of the cache: valid/dirty flags, tags and line data for every set.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset (clears valid/dirty)
//   idx                 : set index for both the combinational read and all writes
//   line_we, line_tag,
//   line_data           : install a whole line (valid=1, dirty=0, new tag)
//   word_we, word_off,
//   word_data           : overwrite one word of the line and mark it dirty
//   clr_dirty           : clear the dirty flag after a write-back
//   rd_entry, rd_line   : combinational read of the selected set
module assoc_cache_way
    import assoc_cache_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int WORDS  = 4,
    parameter int SETS   = 8
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [idx_w(SETS)-1:0]               idx,
    input  logic                                 line_we,
    input  logic [tag_w(ADDR_W, WORDS, SETS)-1:0] line_tag,
    input  logic [DATA_W*WORDS-1:0]              line_data,
    input  logic                                 word_we,
    input  logic [off_w(WORDS)-1:0]              word_off,
    input  logic [DATA_W-1:0]                    word_data,
    input  logic                                 clr_dirty,
    output tag_entry_t                           rd_entry,
    output logic [DATA_W*WORDS-1:0]              rd_line
);

    localparam int OFF_W  = off_w(WORDS);
    localparam int TAG_W  = tag_w(ADDR_W, WORDS, SETS);
    localparam int LINE_W = DATA_W * WORDS;

    logic [SETS-1:0]   valid_reg;
    logic [SETS-1:0]   dirty_reg;
    logic [TAG_W-1:0]  tag_mem  [SETS];
    logic [LINE_W-1:0] data_mem [SETS];
    logic [LINE_W-1:0] merged_line;

    // Word write: replace only the addressed word of the current line.
    genvar gi;
    for (gi = 0; gi < WORDS; gi++) begin : g_merge
        assign merged_line[gi*DATA_W +: DATA_W] =
            (word_off == OFF_W'(gi)) ? word_data : data_mem[idx][gi*DATA_W +: DATA_W];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg <= '0;
            dirty_reg <= '0;
        end else begin
            if (line_we) begin
                valid_reg[idx] <= 1'b1;
                dirty_reg[idx] <= 1'b0;
            end else if (word_we) begin
                dirty_reg[idx] <= 1'b1;
            end else if (clr_dirty) begin
                dirty_reg[idx] <= 1'b0;
            end
        end
    end

    // Tag and data storage carry no reset; valid gates their use.
    always_ff @(posedge clk) begin
        if (line_we) begin
            tag_mem[idx]  <= line_tag;
            data_mem[idx] <= line_data;
        end else if (word_we) begin
            data_mem[idx] <= merged_line;
        end
    end

    assign rd_entry = '{valid: valid_reg[idx],
                        dirty: dirty_reg[idx],
                        tag:   TAG_MAX_W'(tag_mem[idx])};
    assign rd_line  = data_mem[idx];

endmodule

// File: rtl/assoc_cache_ctrl.sv
// Two-way set-associative, write-back, write-allocate cache controller with
// per-set LRU replacement and a whole-cache flush.
// Ports:
//   clk, rst_n                       : clock, asynchronous active-low reset
//   cpu_valid/rw/addr/wdata          : CPU request, held until cpu_ready
//   cpu_ready, cpu_rdata             : one-cycle completion, read data
//   flush_req, flush_done            : level flush request, one-cycle completion
//   mem_valid/rw/addr/wdata          : registered line request to memory
//   mem_ready, mem_rdata             : memory completion and fill data
module assoc_cache_ctrl
    import assoc_cache_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int WORDS  = 4,
    parameter int SETS   = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cpu_valid,
    input  logic                     cpu_rw,
    input  logic [ADDR_W-1:0]        cpu_addr,
    input  logic [DATA_W-1:0]        cpu_wdata,
    output logic                     cpu_ready,
    output logic [DATA_W-1:0]        cpu_rdata,
    input  logic                     flush_req,
    output logic                     flush_done,
    output logic                     mem_valid,
    output logic                     mem_rw,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W*WORDS-1:0]  mem_wdata,
    input  logic                     mem_ready,
    input  logic [DATA_W*WORDS-1:0]  mem_rdata
);

    localparam int OFF_W  = off_w(WORDS);
    localparam int IDX_W  = idx_w(SETS);
    localparam int TAG_W  = tag_w(ADDR_W, WORDS, SETS);
    localparam int LINE_W = DATA_W * WORDS;
    localparam int CNT_W  = IDX_W + 1;

    state_t              state_reg, state_next;
    logic [SETS-1:0]     lru_reg;
    logic                victim_reg, victim_next;
    logic [CNT_W-1:0]    cnt_reg, cnt_next;
    logic                mem_valid_reg, mem_valid_next;
    logic                mem_rw_reg, mem_rw_next;
    logic [ADDR_W-1:0]   mem_addr_reg, mem_addr_next;
    logic [LINE_W-1:0]   mem_wdata_reg, mem_wdata_next;

    logic [OFF_W-1:0]    cpu_off;
    logic [IDX_W-1:0]    cpu_idx;
    logic [TAG_W-1:0]    cpu_tag;
    logic [IDX_W-1:0]    flush_idx;
    logic                flush_way;
    logic                in_flush;
    logic [IDX_W-1:0]    way_idx;

    tag_entry_t          entry [2];
    logic [LINE_W-1:0]   line  [2];
    logic [1:0]          hit_vec;
    logic                hit_way;
    logic [LINE_W-1:0]   hit_line;
    logic [DATA_W-1:0]   hit_words [WORDS];
    logic                victim_sel;
    logic                sel_way;
    tag_entry_t          sel_entry;
    logic [LINE_W-1:0]   sel_line;
    logic                mem_done;

    logic [1:0]          line_we, word_we, clr_dirty;
    logic                lru_we, lru_val;

    assign cpu_off   = cpu_addr[OFF_W-1:0];
    assign cpu_idx   = cpu_addr[OFF_W +: IDX_W];
    assign cpu_tag   = cpu_addr[ADDR_W-1 -: TAG_W];

    // The flush counter walks {set, way}: set in the upper bits, way in bit 0.
    assign flush_idx = cnt_reg[CNT_W-1:1];
    assign flush_way = cnt_reg[0];
    assign in_flush  = (state_reg == FLUSH_SCAN) || (state_reg == FLUSH_WB);
    assign way_idx   = in_flush ? flush_idx : cpu_idx;

    genvar gi;
    for (gi = 0; gi < 2; gi++) begin : g_way
        assign hit_vec[gi] = entry[gi].valid && (entry[gi].tag == TAG_MAX_W'(cpu_tag));

        assoc_cache_way #(
            .ADDR_W (ADDR_W),
            .DATA_W (DATA_W),
            .WORDS  (WORDS),
            .SETS   (SETS)
        ) u_way (
            .clk       (clk),
            .rst_n     (rst_n),
            .idx       (way_idx),
            .line_we   (line_we[gi]),
            .line_tag  (cpu_tag),
            .line_data (mem_rdata),
            .word_we   (word_we[gi]),
            .word_off  (cpu_off),
            .word_data (cpu_wdata),
            .clr_dirty (clr_dirty[gi]),
            .rd_entry  (entry[gi]),
            .rd_line   (line[gi])
        );
    end

    assign hit_way  = hit_vec[1];
    assign hit_line = line[hit_way];

    for (gi = 0; gi < WORDS; gi++) begin : g_word
        assign hit_words[gi] = hit_line[gi*DATA_W +: DATA_W];
    end

    // Fill invalid ways first (way 0 before way 1), otherwise follow LRU.
    assign victim_sel = !entry[0].valid ? 1'b0 :
                        !entry[1].valid ? 1'b1 : lru_reg[cpu_idx];

    assign sel_way   = in_flush ? flush_way : victim_reg;
    assign sel_entry = entry[sel_way];
    assign sel_line  = line[sel_way];

    // Only a request actually on the bus can complete.
    assign mem_done  = mem_valid_reg && mem_ready;

    always_comb begin
        state_next     = state_reg;
        victim_next    = victim_reg;
        cnt_next       = cnt_reg;
        mem_valid_next = mem_valid_reg;
        mem_rw_next    = mem_rw_reg;
        mem_addr_next  = mem_addr_reg;
        mem_wdata_next = mem_wdata_reg;
        line_we        = '0;
        word_we        = '0;
        clr_dirty      = '0;
        lru_we         = 1'b0;
        lru_val        = 1'b0;
        cpu_ready      = 1'b0;
        cpu_rdata      = '0;
        flush_done     = 1'b0;

        // Memory states raise mem_valid on their first cycle and load the
        // request fields only then, so the request stays stable while valid
        // and there is one idle bus cycle between consecutive transactions.
        case (state_reg)
            IDLE: begin
                if (flush_req) begin
                    state_next = FLUSH_SCAN;
                end else if (cpu_valid) begin
                    state_next = COMPARE;
                end
            end

            COMPARE: begin
                if (|hit_vec) begin
                    cpu_ready = 1'b1;
                    if (cpu_rw) begin
                        word_we[hit_way] = 1'b1;
                    end else begin
                        cpu_rdata = hit_words[cpu_off];
                    end
                    lru_we     = 1'b1;
                    lru_val    = ~hit_way;
                    state_next = IDLE;
                end else begin
                    victim_next = victim_sel;
                    if (entry[victim_sel].valid && entry[victim_sel].dirty) begin
                        state_next = WRITE_BACK;
                    end else begin
                        state_next = ALLOCATE;
                    end
                end
            end

            WRITE_BACK, FLUSH_WB: begin
                if (mem_done) begin
                    mem_valid_next     = 1'b0;
                    clr_dirty[sel_way] = 1'b1;
                    state_next = (state_reg == FLUSH_WB) ? FLUSH_SCAN : ALLOCATE;
                end else if (!mem_valid_reg) begin
                    mem_valid_next = 1'b1;
                    mem_rw_next    = 1'b1;
                    mem_addr_next  = {sel_entry.tag[TAG_W-1:0], way_idx, {OFF_W{1'b0}}};
                    mem_wdata_next = sel_line;
                end
            end

            ALLOCATE: begin
                if (mem_done) begin
                    mem_valid_next      = 1'b0;
                    line_we[victim_reg] = 1'b1;
                    state_next          = COMPARE;
                end else if (!mem_valid_reg) begin
                    mem_valid_next = 1'b1;
                    mem_rw_next    = 1'b0;
                    mem_addr_next  = {cpu_tag, cpu_idx, {OFF_W{1'b0}}};
                    mem_wdata_next = '0;
                end
            end

            FLUSH_SCAN: begin
                // The counter holds on a dirty entry; after its write-back the
                // entry reads clean and the scan moves on.
                if (sel_entry.valid && sel_entry.dirty) begin
                    state_next = FLUSH_WB;
                end else if (cnt_reg == {CNT_W{1'b1}}) begin
                    flush_done = 1'b1;
                    cnt_next   = '0;
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end

            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            lru_reg       <= '0;
            victim_reg    <= 1'b0;
            cnt_reg       <= '0;
            mem_valid_reg <= 1'b0;
            mem_rw_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
        end else begin
            state_reg     <= state_next;
            victim_reg    <= victim_next;
            cnt_reg       <= cnt_next;
            mem_valid_reg <= mem_valid_next;
            mem_rw_reg    <= mem_rw_next;
            mem_addr_reg  <= mem_addr_next;
            mem_wdata_reg <= mem_wdata_next;
            if (lru_we) begin
                lru_reg[cpu_idx] <= lru_val;
            end
        end
    end

    assign mem_valid = mem_valid_reg;
    assign mem_rw    = mem_rw_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;

endmodule

// File: tb/tb_assoc_cache_ctrl.sv
module tb_assoc_cache_ctrl;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;
    localparam int WORDS  = 4;
    localparam int SETS   = 8;
    localparam int LINE_W = DATA_W * WORDS;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cpu_valid = 1'b0, cpu_rw = 1'b0;
    logic [ADDR_W-1:0] cpu_addr = '0;
    logic [DATA_W-1:0] cpu_wdata = '0;
    logic              cpu_ready;
    logic [DATA_W-1:0] cpu_rdata;
    logic              flush_req = 1'b0, flush_done;
    logic              mem_valid, mem_rw;
    logic [ADDR_W-1:0] mem_addr;
    logic [LINE_W-1:0] mem_wdata;
    logic              mem_ready;
    logic [LINE_W-1:0] mem_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    assoc_cache_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WORDS(WORDS), .SETS(SETS)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_valid(cpu_valid), .cpu_rw(cpu_rw), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
        .flush_req(flush_req), .flush_done(flush_done),
        .mem_valid(mem_valid), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    typedef struct packed {
        logic              rw;
        logic [ADDR_W-1:0] addr;
        logic [LINE_W-1:0] wdata;
    } mtx_t;

    mtx_t obs_q[$];
    mtx_t exp_q[$];

    // Memory: "mem_img" is what the responder serves, "model_mem" is the
    // reference model's belief. Unwritten lines have an address-derived value.
    logic [LINE_W-1:0] mem_img   [int];
    logic [LINE_W-1:0] model_mem [int];

    function automatic logic [LINE_W-1:0] line_init(input int a);
        logic [LINE_W-1:0] l;
        for (int k = 0; k < WORDS; k++) l[k*DATA_W +: DATA_W] = DATA_W'(a * 7 + k * 13 + 'h3C00);
        return l;
    endfunction

    function automatic logic [LINE_W-1:0] img_rd(input int a);
        return mem_img.exists(a) ? mem_img[a] : line_init(a);
    endfunction

    function automatic logic [LINE_W-1:0] model_rd(input int a);
        return model_mem.exists(a) ? model_mem[a] : line_init(a);
    endfunction

    // Memory responder: random latency 0..3 extra cycles, logs every request
    // and checks that a pending request does not change.
    initial begin
        int   stall;
        logic busy;
        mtx_t cur, now_t;
        mem_ready = 1'b0;
        mem_rdata = '0;
        busy = 1'b0;
        stall = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                busy = 1'b0;
                mem_ready = 1'b0;
            end else if (mem_ready) begin
                mem_ready = 1'b0;
                busy = 1'b0;
            end else if (mem_valid) begin
                now_t.rw = mem_rw; now_t.addr = mem_addr; now_t.wdata = mem_wdata;
                if (!busy) begin
                    busy = 1'b1;
                    cur = now_t;
                    obs_q.push_back(cur);
                    stall = $urandom_range(0, 3);
                end else begin
                    n_tests++;
                    if (now_t !== cur) begin
                        n_fail++;
                        $display("FAIL mem_stable got addr=%h rw=%0b want addr=%h rw=%0b", now_t.addr, now_t.rw, cur.addr, cur.rw);
                    end
                end
                if (stall == 0) begin
                    mem_ready = 1'b1;
                    if (cur.rw) mem_img[int'(cur.addr)] = cur.wdata;
                    else mem_rdata = img_rd(int'(cur.addr));
                end else begin
                    stall--;
                end
            end
        end
    end

    // Reference model: plain per-set arrays indexed with address arithmetic.
    logic              m_valid [SETS][2];
    logic              m_dirty [SETS][2];
    int                m_tag   [SETS][2];
    logic [LINE_W-1:0] m_line  [SETS][2];
    int                m_lru   [SETS];

    task automatic model_reset;
        for (int s = 0; s < SETS; s++) begin
            m_lru[s] = 0;
            for (int w = 0; w < 2; w++) begin m_valid[s][w] = 0; m_dirty[s][w] = 0; m_tag[s][w] = 0; end
        end
    endtask

    task automatic model_access(input logic rw, input int addr, input logic [DATA_W-1:0] wd,
                                output logic [DATA_W-1:0] rd, output logic hit);
        int   s   = (addr / WORDS) % SETS;
        int   t   = addr / (WORDS * SETS);
        int   off = addr % WORDS;
        int   w   = -1;
        int   la;
        mtx_t e;
        for (int k = 0; k < 2; k++) if (m_valid[s][k] && m_tag[s][k] == t) w = k;
        hit = (w >= 0);
        if (w < 0) begin
            w = !m_valid[s][0] ? 0 : (!m_valid[s][1] ? 1 : m_lru[s]);
            if (m_valid[s][w] && m_dirty[s][w]) begin
                la = (m_tag[s][w] * SETS + s) * WORDS;
                e.rw = 1'b1; e.addr = ADDR_W'(la); e.wdata = m_line[s][w];
                exp_q.push_back(e);
                model_mem[la] = m_line[s][w];
            end
            la = (t * SETS + s) * WORDS;
            e.rw = 1'b0; e.addr = ADDR_W'(la); e.wdata = '0;
            exp_q.push_back(e);
            m_line[s][w] = model_rd(la);
            m_valid[s][w] = 1; m_dirty[s][w] = 0; m_tag[s][w] = t;
        end
        rd = m_line[s][w][off*DATA_W +: DATA_W];
        if (rw) begin
            m_line[s][w][off*DATA_W +: DATA_W] = wd;
            m_dirty[s][w] = 1;
        end
        m_lru[s] = 1 - w;
    endtask

    task automatic model_flush;
        int   la;
        mtx_t e;
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < 2; w++)
                if (m_valid[s][w] && m_dirty[s][w]) begin
                    la = (m_tag[s][w] * SETS + s) * WORDS;
                    e.rw = 1'b1; e.addr = ADDR_W'(la); e.wdata = m_line[s][w];
                    exp_q.push_back(e);
                    model_mem[la] = m_line[s][w];
                    m_dirty[s][w] = 0;
                end
    endtask

    // One CPU transaction; call at a time away from the clock edge.
    task automatic cpu_op(input logic rw, input int addr, input logic [DATA_W-1:0] wd, input string nm);
        logic [DATA_W-1:0] exp_rd, got;
        logic              exp_hit;
        int                cyc;
        bit                done;
        model_access(rw, addr, wd, exp_rd, exp_hit);
        cpu_valid = 1'b1; cpu_rw = rw; cpu_addr = ADDR_W'(addr); cpu_wdata = wd;
        cyc = 0; done = 0; got = '0;
        while (!done && cyc < 200) begin
            @(negedge clk); cyc++;
            if (cpu_ready) begin done = 1; got = cpu_rdata; end
        end
        @(posedge clk); #1;
        cpu_valid = 1'b0;
        $display("[TB] %s rw=%0b addr=%h wdata=%h rdata=%h hit=%0b cycles=%0d", nm, rw, addr[15:0], wd, got, exp_hit, cyc);
        n_tests++;
        if (!done) begin
            n_fail++; $display("FAIL %s ready_timeout got none want cpu_ready", nm);
        end else begin
            if (!rw) begin
                n_tests++;
                if (got !== exp_rd) begin n_fail++; $display("FAIL %s rdata got %h want %h", nm, got, exp_rd); end
            end
            if (exp_hit) begin
                n_tests++;
                if (cyc != 2) begin n_fail++; $display("FAIL %s hit_latency got %0d want 2", nm, cyc); end
            end
        end
        n_tests++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL %s mem_count got %0d want %0d", nm, obs_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i])
                if (obs_q[i].rw !== exp_q[i].rw || obs_q[i].addr !== exp_q[i].addr ||
                    (exp_q[i].rw && obs_q[i].wdata !== exp_q[i].wdata)) begin
                    n_fail++;
                    $display("FAIL %s mem_tx%0d got rw=%0b addr=%h data=%h want rw=%0b addr=%h data=%h", nm, i,
                             obs_q[i].rw, obs_q[i].addr, obs_q[i].wdata, exp_q[i].rw, exp_q[i].addr, exp_q[i].wdata);
                end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic do_flush(input int exp_cyc, input string nm);
        int cyc, highs;
        bit done;
        model_flush();
        flush_req = 1'b1;
        cyc = 0; done = 0; highs = 0;
        while (!done && cyc < 500) begin
            @(negedge clk); cyc++;
            if (flush_done) done = 1;
        end
        @(posedge clk); #1;
        flush_req = 1'b0;
        $display("[TB] %s flush cycles=%0d writebacks=%0d", nm, cyc, obs_q.size());
        n_tests++;
        if (!done) begin
            n_fail++; $display("FAIL %s flush_timeout got none want flush_done", nm);
        end else if (exp_cyc > 0) begin
            n_tests++;
            if (cyc != exp_cyc) begin n_fail++; $display("FAIL %s flush_cycles got %0d want %0d", nm, cyc, exp_cyc); end
        end
        repeat (3) begin @(negedge clk); if (flush_done) highs++; end
        n_tests++;
        if (highs != 0) begin n_fail++; $display("FAIL %s flush_done_pulse got %0d extra want 0", nm, highs); end
        n_tests++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL %s wb_count got %0d want %0d", nm, obs_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i])
                if (obs_q[i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL %s wb%0d got rw=%0b addr=%h data=%h want rw=%0b addr=%h data=%h", nm, i,
                             obs_q[i].rw, obs_q[i].addr, obs_q[i].wdata, exp_q[i].rw, exp_q[i].addr, exp_q[i].wdata);
                end
        end
        obs_q.delete(); exp_q.delete();
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_tests += 7;
        if (cpu_ready !== 1'b0) begin n_fail++; $display("FAIL reset cpu_ready got %b want 0", cpu_ready); end
        if (cpu_rdata !== '0) begin n_fail++; $display("FAIL reset cpu_rdata got %h want 0", cpu_rdata); end
        if (flush_done !== 1'b0) begin n_fail++; $display("FAIL reset flush_done got %b want 0", flush_done); end
        if (mem_valid !== 1'b0) begin n_fail++; $display("FAIL reset mem_valid got %b want 0", mem_valid); end
        if (mem_rw !== 1'b0) begin n_fail++; $display("FAIL reset mem_rw got %b want 0", mem_rw); end
        if (mem_addr !== '0) begin n_fail++; $display("FAIL reset mem_addr got %h want 0", mem_addr); end
        if (mem_wdata !== '0) begin n_fail++; $display("FAIL reset mem_wdata got %h want 0", mem_wdata); end
        rst_n = 1'b1;
        model_reset();
        @(posedge clk); #1;
    endtask

    task automatic test_cold_read_and_write_hit;
        mem_img['h24]   = 64'h4444_3333_2222_1111;
        model_mem['h24] = 64'h4444_3333_2222_1111;
        cpu_op(1'b0, 'h24, '0, "cold_read");
        cpu_op(1'b0, 'h25, '0, "reread_hit");
        cpu_op(1'b1, 'h26, 16'hBEEF, "write_hit");
        cpu_op(1'b0, 'h26, '0, "read_back");
    endtask

    task automatic test_lru_victim;
        cpu_op(1'b0, 'h424, '0, "fill_way1");
        cpu_op(1'b1, 'h424, 16'h1234, "dirty_way1");
        cpu_op(1'b0, 'h24, '0, "touch_way0");
        cpu_op(1'b0, 'h824, '0, "evict_way1");
        cpu_op(1'b0, 'h24, '0, "way0_still_hit");
    endtask

    task automatic test_flush;
        cpu_op(1'b1, 'h48, 16'hCAFE, "dirty_set2");
        do_flush(-1, "flush_two");
        do_flush(1 + 2 * SETS, "flush_clean");
        cpu_op(1'b0, 'h24, '0, "post_flush_hit_a");
        cpu_op(1'b0, 'h48, '0, "post_flush_hit_b");
    endtask

    task automatic test_reset_mid;
        int  cyc;
        bit  seen;
        cpu_valid = 1'b1; cpu_rw = 1'b0; cpu_addr = 16'h00C0;
        cyc = 0; seen = 0;
        while (!seen && cyc < 50) begin
            @(negedge clk); cyc++;
            if (mem_valid && !mem_rw) seen = 1;
        end
        n_tests++;
        if (!seen) begin n_fail++; $display("FAIL reset_mid fill_request got none want mem_valid"); end
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if (mem_valid !== 1'b0) begin n_fail++; $display("FAIL reset_mid mem_valid got %b want 0", mem_valid); end
        cpu_valid = 1'b0;
        @(negedge clk); #2;
        rst_n = 1'b1;
        obs_q.delete(); exp_q.delete();
        model_reset();
        @(posedge clk); #1;
        cpu_op(1'b0, 'h24, '0, "after_reset_miss");
    endtask

    task automatic test_flush_priority;
        logic [DATA_W-1:0] exp_rd, got;
        logic              exp_hit;
        int                cyc;
        bit                fdone, cdone, order_bad;
        cpu_op(1'b1, 'h24, 16'h5555, "prio_dirty");
        model_flush();
        model_access(1'b0, 'h24, '0, exp_rd, exp_hit);
        flush_req = 1'b1; cpu_valid = 1'b1; cpu_rw = 1'b0; cpu_addr = 16'h0024;
        cyc = 0; fdone = 0; cdone = 0; order_bad = 0; got = '0;
        while (!cdone && cyc < 500) begin
            @(negedge clk); cyc++;
            if (cpu_ready && !fdone) order_bad = 1;
            if (cpu_ready) begin cdone = 1; got = cpu_rdata; end
            if (flush_done) begin fdone = 1; @(posedge clk); #1 flush_req = 1'b0; end
        end
        @(posedge clk); #1;
        cpu_valid = 1'b0; flush_req = 1'b0;
        $display("[TB] prio flush_done=%0b cpu_done=%0b rdata=%h cycles=%0d", fdone, cdone, got, cyc);
        n_tests += 3;
        if (!fdone || order_bad) begin n_fail++; $display("FAIL prio order got flush_first=%0b want 1", fdone && !order_bad); end
        if (!cdone) begin n_fail++; $display("FAIL prio cpu_timeout got none want cpu_ready"); end
        if (got !== exp_rd) begin n_fail++; $display("FAIL prio rdata got %h want %h", got, exp_rd); end
        n_tests++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL prio mem_count got %0d want %0d", obs_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i])
                if (obs_q[i].rw !== exp_q[i].rw || obs_q[i].addr !== exp_q[i].addr) begin
                    n_fail++;
                    $display("FAIL prio mem_tx%0d got rw=%0b addr=%h want rw=%0b addr=%h", i,
                             obs_q[i].rw, obs_q[i].addr, exp_q[i].rw, exp_q[i].addr);
                end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_random;
        int t, s, off;
        for (int i = 0; i < 60; i++) begin
            t = $urandom_range(0, 3); s = $urandom_range(0, SETS - 1); off = $urandom_range(0, WORDS - 1);
            cpu_op(1'($urandom_range(0, 1)), (t * SETS + s) * WORDS + off, DATA_W'($urandom), "rand");
            if (i % 20 == 19) do_flush(-1, "rand_flush");
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_cold_read_and_write_hit();
        test_lru_victim();
        test_flush();
        test_reset_mid();
        test_flush_priority();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
